// File: rtl/leg_fetch_pkg.sv
// leg_fetch_pkg: shared fetch-queue defaults and the queued entry layout
package leg_fetch_pkg;
    localparam int          DEF_QDEPTH   = 4;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: power-of-two circular queue of fetch entries with flush
module fetch_fifo
    import leg_fetch_pkg::*;
#(
    parameter int DEPTH = DEF_QDEPTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t wdata,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);
    localparam int AW = $clog2(DEPTH);
    logic [AW-1:0] hd, tl;
    logic [AW:0]   cnt;
    fetch_entry_t  mem [DEPTH];
    logic          do_push, do_pop;
    assign full    = cnt == (AW+1)'(DEPTH);
    assign empty   = cnt == '0;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[hd];
    // pointers wrap naturally because DEPTH is a power of two; flush drops every entry
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            hd  <= '0;
            tl  <= '0;
            cnt <= '0;
        end else begin
            hd  <= hd + AW'(do_pop);
            tl  <= tl + AW'(do_push);
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    // storage is zeroed on reset so the head reads a defined value while empty
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push && !flush) begin
            mem[tl] <= wdata;
        end
    end
endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: sequential instruction prefetcher feeding decode through a small queue
module ifetch_queue
    import leg_fetch_pkg::*;
#(
    parameter int          QDEPTH   = DEF_QDEPTH,
    parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_a,
    input  logic [31:0] imem_rd,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        ready_d,
    output logic        valid_d,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc8_d
);
    logic [31:0]  fetch_pc;
    logic         full, empty, enq, deq;
    fetch_entry_t hd;
    assign valid_d = ~empty;
    assign deq     = valid_d & ready_d & ~redirect;
    assign enq     = ~redirect & (~full | deq);
    assign imem_a  = fetch_pc;
    assign instr_d = hd.instr;
    assign pc_d    = hd.pc;
    assign pc8_d   = hd.pc + 32'd8;
    fetch_fifo #(.DEPTH(QDEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (redirect),
        .push  (enq),
        .pop   (deq),
        .wdata ('{instr: imem_rd, pc: fetch_pc}),
        .full  (full),
        .empty (empty),
        .head  (hd)
    );
    // fetch address: reset beats redirect, otherwise advance only when a word is enqueued
    always_ff @(posedge clk) begin
        fetch_pc <= reset    ? (RESET_PC & ~32'h3) :
                    redirect ? (redirect_pc & ~32'h3) :
                    enq      ? fetch_pc + 32'd4 : fetch_pc;
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: table vectors, corner sequences and random traffic against a queue model
module tb_ifetch_queue;
    localparam int          QDEPTH   = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    logic        clk = 0;
    logic        reset = 1, redirect = 0, ready_d = 0;
    logic [31:0] redirect_pc = 0;
    logic [31:0] imem_a, imem_rd, instr_d, pc_d, pc8_d;
    logic        valid_d;
    int          checks = 0, failures = 0;
    typedef struct packed { logic [31:0] instr; logic [31:0] pc; } ent_t;
    ent_t        q[$];
    logic [31:0] mpc;
    bit          after_reset;
    typedef struct {
        logic r, rd; logic [31:0] rpc; logic rdy;
        logic ev; logic [31:0] epc, ea;
    } vec_t;
    vec_t tv[16];

    ifetch_queue #(.QDEPTH(QDEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset), .imem_a(imem_a), .imem_rd(imem_rd),
        .redirect(redirect), .redirect_pc(redirect_pc), .ready_d(ready_d),
        .valid_d(valid_d), .instr_d(instr_d), .pc_d(pc_d), .pc8_d(pc8_d)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return 32'hE000_0000 + {2'b00, a[31:2]};
    endfunction

    assign imem_rd = memw(imem_a);

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", n, a, e, $time);
        end
    endtask

    task automatic step(input logic r, input logic rd, input logic [31:0] rpc, input logic rdy);
        bit dq, eq;
        reset = r; redirect = rd; redirect_pc = rpc; ready_d = rdy;
        @(posedge clk);
        after_reset = r;
        if (r) begin
            q.delete();
            mpc = RESET_PC;
        end else if (rd) begin
            q.delete();
            mpc = rpc & ~32'h3;
        end else begin
            dq = q.size() != 0 && rdy;
            eq = q.size() < QDEPTH || dq;
            if (dq) void'(q.pop_front());
            if (eq) begin
                q.push_back('{instr: memw(mpc), pc: mpc});
                mpc = mpc + 32'd4;
            end
        end
        @(negedge clk);
        chk("valid_d", {31'b0, valid_d}, {31'b0, q.size() != 0});
        chk("imem_a", imem_a, mpc);
        if (q.size() != 0) begin
            chk("instr_d", instr_d, q[0].instr);
            chk("pc_d", pc_d, q[0].pc);
            chk("pc8_d", pc8_d, q[0].pc + 32'd8);
        end else if (after_reset) begin
            chk("rst_instr_d", instr_d, 32'h0);
            chk("rst_pc_d", pc_d, 32'h0);
            chk("rst_pc8_d", pc8_d, 32'h8);
        end
    endtask

    initial begin
        logic [31:0] b;
        tv[0]  = '{1, 0, 32'h0,        0, 0, 32'h0,        32'h0};
        tv[1]  = '{0, 0, 32'h0,        1, 1, 32'h0,        32'h4};
        tv[2]  = '{0, 0, 32'h0,        1, 1, 32'h4,        32'h8};
        tv[3]  = '{0, 0, 32'h0,        1, 1, 32'h8,        32'hC};
        tv[4]  = '{0, 1, 32'h203,      1, 0, 32'h0,        32'h200};
        tv[5]  = '{0, 0, 32'h0,        1, 1, 32'h200,      32'h204};
        tv[6]  = '{0, 0, 32'h0,        0, 1, 32'h200,      32'h208};
        tv[7]  = '{0, 0, 32'h0,        0, 1, 32'h200,      32'h20C};
        tv[8]  = '{0, 0, 32'h0,        0, 1, 32'h200,      32'h210};
        tv[9]  = '{0, 0, 32'h0,        0, 1, 32'h200,      32'h210};
        tv[10] = '{0, 0, 32'h0,        1, 1, 32'h204,      32'h214};
        tv[11] = '{0, 1, 32'hFFFFFFF8, 1, 0, 32'h0,        32'hFFFFFFF8};
        tv[12] = '{0, 0, 32'h0,        1, 1, 32'hFFFFFFF8, 32'hFFFFFFFC};
        tv[13] = '{0, 0, 32'h0,        1, 1, 32'hFFFFFFFC, 32'h0};
        tv[14] = '{0, 0, 32'h0,        1, 1, 32'h0,        32'h4};
        tv[15] = '{1, 1, 32'h300,      1, 0, 32'h0,        32'h0};
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            step(tv[i].r, tv[i].rd, tv[i].rpc, tv[i].rdy);
            chk($sformatf("tv%0d_valid", i), {31'b0, valid_d}, {31'b0, tv[i].ev});
            chk($sformatf("tv%0d_imem_a", i), imem_a, tv[i].ea);
            if (tv[i].ev) begin
                chk($sformatf("tv%0d_pc", i), pc_d, tv[i].epc);
                chk($sformatf("tv%0d_pc8", i), pc8_d, tv[i].epc + 32'd8);
                chk($sformatf("tv%0d_instr", i), instr_d, memw(tv[i].epc));
            end
        end
        // stalled decode fills the queue, then drains with no bubble
        step(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
        chk("stall_imem_a", imem_a, 32'h10);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("drain_pc%0d", k), pc_d, 32'(4 * k));
            step(0, 0, 0, 1);
        end
        // reset mid-stream with three entries queued
        step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        step(1, 0, 0, 1);
        chk("midrst_valid", {31'b0, valid_d}, 32'h0);
        chk("midrst_imem_a", imem_a, RESET_PC);
        // back-to-back redirects, last one wins
        step(0, 1, 32'h1000, 1);
        step(0, 1, 32'h2006, 1);
        chk("b2b_valid", {31'b0, valid_d}, 32'h0);
        chk("b2b_imem_a", imem_a, 32'h2004);
        step(0, 0, 0, 1);
        chk("b2b_pc", pc_d, 32'h2004);
        // full queue streaming: one new pc per cycle, no drop or duplicate
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
        b = pc_d;
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("stream_pc%0d", i), pc_d, b + 32'(4 * i));
            step(0, 0, 0, 1);
        end
        chk("stream_imem_a", imem_a, b + 32'd16 + 32'd80);
        // random traffic against the model
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 5,
                 ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : $urandom,
                 $urandom_range(0, 99) < 60);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter QDEPTH, default 4, SHALL set the prefetch queue depth in entries (power of two, 2..16).
REQ-002 Parameter RESET_PC, default 32'h00000000, SHALL set the first fetch address after reset.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 imem_a  output  32  SHALL be the fetch byte address to instruction memory; bits [1:0] always 0.
REQ-006 imem_rd  input  32  SHALL be the instruction word from memory, combinational from imem_a in the same cycle.
REQ-007 redirect  input  1  SHALL request a fetch-stream restart (branch/exception) when high.
REQ-008 redirect_pc  input  32  SHALL be the restart byte address, sampled when redirect is high.
REQ-009 ready_d  input  1  SHALL indicate decode accepts the head entry this cycle.
REQ-010 valid_d  output  1  SHALL indicate instr_d/pc_d/pc8_d hold a valid queued instruction.
REQ-011 instr_d  output  32  SHALL be the head entry's instruction word.
REQ-012 pc_d  output  32  SHALL be the head entry's fetch address.
REQ-013 pc8_d  output  32  SHALL be pc_d + 8 modulo 2^32 (architectural PC read value).

Function
REQ-014 Internal fetch_pc register SHALL drive imem_a directly.
REQ-015 Enqueue SHALL occur when redirect is low and (count < QDEPTH or a dequeue occurs the same cycle); it writes {imem_rd, fetch_pc} at tail and sets fetch_pc <= fetch_pc + 4.
REQ-016 When no enqueue occurs and redirect is low, fetch_pc SHALL hold.
REQ-017 Dequeue SHALL occur when valid_d & ready_d & ~redirect, advancing head by one.
REQ-018 valid_d SHALL equal (count != 0); outputs SHALL come from registered queue storage only (no combinational path imem_rd -> instr_d).
REQ-019 Latency: a word enqueued in cycle N SHALL appear at the head no earlier than cycle N+1; with empty queue and ready_d high, throughput SHALL be one instruction per cycle.
REQ-020 Simultaneous enqueue and dequeue SHALL leave count unchanged, including when count == QDEPTH.
REQ-021 Full (count == QDEPTH) without dequeue SHALL block enqueue; fetch_pc SHALL hold.
REQ-022 Head/tail pointers SHALL wrap modulo QDEPTH; count SHALL never exceed QDEPTH nor underflow.
REQ-023 fetch_pc + 4 SHALL wrap 32'hFFFFFFFC -> 32'h00000000.
REQ-024 redirect high SHALL, at the next edge, empty the queue (count 0, head = tail), set fetch_pc <= {redirect_pc[31:2], 2'b00}, and suppress both enqueue and dequeue that cycle.
REQ-025 Consequently valid_d SHALL be 0 in the cycle after redirect, and the first instruction from redirect_pc SHALL be valid two cycles after redirect.
REQ-026 Back-to-back redirects SHALL each take effect; the last one wins.
REQ-027 instr_d/pc_d contents while valid_d is low are don't-care for decode but SHALL be stable (no X after reset).

Reset
REQ-028 During reset high: fetch_pc <= RESET_PC, count <= 0, head <= 0, tail <= 0; no enqueue/dequeue.
REQ-029 After the reset edge: valid_d = 0, imem_a = RESET_PC, instr_d = 0, pc_d = 0, pc8_d = 8.
REQ-030 Reset SHALL take priority over redirect; reset asserted mid-stream SHALL discard all queued entries.

Structure
REQ-031 Package leg_fetch_pkg SHALL hold the default QDEPTH, default RESET_PC, and the fetch_entry_t struct {instr[31:0], pc[31:0]}.
REQ-032 Queue storage and pointers SHALL be in sub-module fetch_fifo (push, pop, flush, full, empty, head entry); ifetch_queue holds fetch_pc and control.

Verification
REQ-033 Reset, ready_d=1, memory word k = 32'hE000_0000+k -> valid_d from 2nd cycle, pc_d = 0,4,8,... one per cycle, instr_d matching.
REQ-034 ready_d=0 for 10 cycles after reset -> exactly 4 entries queued, imem_a holds 32'h10, then ready_d=1 yields pc_d 0,4,8,12,16 with no gap.
REQ-035 Full queue, redirect=1 with redirect_pc=32'h0000_0203 -> next cycle valid_d=0, imem_a=32'h200; cycle after, valid_d=1, pc_d=32'h200, pc8_d=32'h208.
REQ-036 Redirect to 32'hFFFF_FFF8, ready_d=1 -> pc_d sequence FFFFFFF8, FFFFFFFC, 00000000.
REQ-037 Reset asserted one cycle with 3 entries queued -> valid_d=0 next cycle, imem_a=RESET_PC.
REQ-038 Full queue with ready_d=1 continuous -> count stays 4, one new pc per cycle, no dropped or duplicated address (scoreboard).
